// File: rtl/vproc_bus_arbiter_if.sv
// Bus bundle between the VProc masters, the arbiter and one target.
// slave = arbiter view, master = environment view.
interface vproc_bus_arbiter_if #(
  parameter int NUM_MASTERS = 2
);
  logic [32*NUM_MASTERS-1:0] M_Addr;
  logic [4*NUM_MASTERS-1:0]  M_BE;
  logic [NUM_MASTERS-1:0]    M_WE;
  logic [NUM_MASTERS-1:0]    M_RD;
  logic [32*NUM_MASTERS-1:0] M_DataOut;
  logic [12*NUM_MASTERS-1:0] M_Burst;
  logic [NUM_MASTERS-1:0]    M_BurstFirst;
  logic [NUM_MASTERS-1:0]    M_BurstLast;
  logic [31:0]               M_DataIn;
  logic [NUM_MASTERS-1:0]    M_WRAck;
  logic [NUM_MASTERS-1:0]    M_RDAck;

  logic [31:0] T_Addr;
  logic [3:0]  T_BE;
  logic        T_WE;
  logic        T_RD;
  logic [31:0] T_DataOut;
  logic [11:0] T_Burst;
  logic        T_BurstFirst;
  logic        T_BurstLast;
  logic [31:0] T_DataIn;
  logic        T_WRAck;
  logic        T_RDAck;

  logic [NUM_MASTERS-1:0] Grant;

  modport slave (
    input  M_Addr, M_BE, M_WE, M_RD, M_DataOut,
    input  M_Burst, M_BurstFirst, M_BurstLast,
    input  T_DataIn, T_WRAck, T_RDAck,
    output M_DataIn, M_WRAck, M_RDAck,
    output T_Addr, T_BE, T_WE, T_RD, T_DataOut,
    output T_Burst, T_BurstFirst, T_BurstLast,
    output Grant
  );

  modport master (
    output M_Addr, M_BE, M_WE, M_RD, M_DataOut,
    output M_Burst, M_BurstFirst, M_BurstLast,
    output T_DataIn, T_WRAck, T_RDAck,
    input  M_DataIn, M_WRAck, M_RDAck,
    input  T_Addr, T_BE, T_WE, T_RD, T_DataOut,
    input  T_Burst, T_BurstFirst, T_BurstLast,
    input  Grant
  );
endinterface

// File: rtl/vproc_bus_arbiter.sv
// Round-robin arbiter sharing one target bus between VProc masters.
// Grant is locked for a whole burst; acks go back to the owner only.
module vproc_bus_arbiter #(
  parameter int NUM_MASTERS = 2
) (
  input logic                Clk,
  input logic                nReset,
  vproc_bus_arbiter_if.slave bus
);

  localparam int N  = NUM_MASTERS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE,
    OWNED
  } state_e;

  state_e          state_q;
  logic [N-1:0]    grant_q;
  logic [IW-1:0]   last_q;

  logic [N-1:0]    req;
  logic            pick_vld;
  logic [IW-1:0]   pick_idx;
  logic [IW:0]     cand;
  logic [N-1:0]    pick_oh;

  logic [31:0]     g_addr;
  logic [31:0]     g_dout;
  logic [3:0]      g_be;
  logic [11:0]     g_burst;
  logic            g_rd;
  logic            g_we;
  logic            g_bf;
  logic            g_bl;
  logic            g_req;
  logic            g_ack;
  logic            g_done;

  assign req = bus.M_RD | bus.M_WE;

  // scan last+1, last+2, ... wrapping at N
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = 1; k <= N; k++) begin
      cand = {1'b0, last_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(N))
        cand = cand - (IW+1)'(N);
      if (!pick_vld && req[cand[IW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[IW-1:0];
      end
    end
  end

  assign pick_oh = {{(N-1){1'b0}}, 1'b1} << pick_idx;

  // AND-OR mux: all zero while no master owns the bus
  always_comb begin
    g_addr  = '0;
    g_dout  = '0;
    g_be    = '0;
    g_burst = '0;
    g_rd    = 1'b0;
    g_we    = 1'b0;
    g_bf    = 1'b0;
    g_bl    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (grant_q[i]) begin
        g_addr  |= bus.M_Addr[32*i +: 32];
        g_dout  |= bus.M_DataOut[32*i +: 32];
        g_be    |= bus.M_BE[4*i +: 4];
        g_burst |= bus.M_Burst[12*i +: 12];
        g_rd    |= bus.M_RD[i];
        g_we    |= bus.M_WE[i];
        g_bf    |= bus.M_BurstFirst[i];
        g_bl    |= bus.M_BurstLast[i];
      end
    end
  end

  assign g_req  = g_rd | g_we;
  assign g_ack  = g_req & (bus.T_WRAck | bus.T_RDAck);
  assign g_done = g_ack & ((g_burst == 12'd0) | g_bl);

  assign bus.T_Addr       = g_addr;
  assign bus.T_BE         = g_be;
  assign bus.T_WE         = g_we;
  assign bus.T_RD         = g_rd;
  assign bus.T_DataOut    = g_dout;
  assign bus.T_Burst      = g_burst;
  assign bus.T_BurstFirst = g_bf;
  assign bus.T_BurstLast  = g_bl;

  // acks with no live request are a target error and are dropped
  assign bus.M_DataIn = bus.T_DataIn;
  assign bus.M_WRAck  = grant_q & {N{bus.T_WRAck & g_req}};
  assign bus.M_RDAck  = grant_q & {N{bus.T_RDAck & g_req}};
  assign bus.Grant    = grant_q;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(N-1);
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pick_vld) begin
            grant_q <= pick_oh;
            last_q  <= pick_idx;
            state_q <= OWNED;
          end
        end
        OWNED: begin
          if (!g_req || g_done) begin
            grant_q <= '0;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
